// File: rtl/uart_rx_poller.sv
// Wishbone read master that polls a 16550 LSR, drains RBR into a local FIFO,
// and flags line terminators, UART overruns and bus errors.
module uart_rx_poller #(
    parameter int POLL_INTERVAL = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                          clk_tb,
    input  logic                          reset_tb,
    input  logic                          enable,
    output logic [31:0]                   wb_adr_o,
    output logic [31:0]                   wb_dat_o,
    input  logic [31:0]                   wb_dat_i,
    output logic [3:0]                    wb_sel_o,
    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    output logic                          wb_we_o,
    input  logic                          wb_ack_i,
    input  logic                          wb_err_i,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          line_done,
    output logic                          uart_overrun,
    output logic                          bus_error,
    input  logic                          flags_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(POLL_INTERVAL + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, LSR_RD, RBR_RD} state_t;

    state_t          state;
    logic [PW-1:0]   wcnt;
    logic [TW-1:0]   tcnt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]   count_next;
    logic [7:0]      head_next;
    logic            full, do_push, do_pop, abort, lsr_ack;
    logic            unused_dat;

    assign wb_dat_o   = '0;
    assign wb_we_o    = 1'b0;
    assign unused_dat = &{1'b0, wb_dat_i[31:10]};

    assign full     = fifo_count == CW'(FIFO_DEPTH);
    assign do_pop   = rx_valid && rx_ready;
    // err takes priority over ack; an ack on the last allowed cycle still counts
    assign abort    = wb_cyc_o && (wb_err_i || (!wb_ack_i && tcnt == TW'(ACK_TIMEOUT - 1)));
    assign lsr_ack  = (state == LSR_RD) && wb_cyc_o && wb_ack_i && !wb_err_i;
    assign do_push  = (state == RBR_RD) && wb_cyc_o && wb_ack_i && !wb_err_i && (!full || do_pop);

    assign rd_next    = rd_ptr + AW'(do_pop);
    assign count_next = fifo_count + CW'(do_push) - CW'(do_pop);
    // a push into a FIFO that is empty after this cycle's pop becomes the new head directly
    assign head_next  = (do_push && fifo_count == CW'(do_pop)) ? wb_dat_i[7:0] : mem[rd_next];

    always_ff @(posedge clk_tb) begin
        if (do_push) mem[wr_ptr] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            line_done  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_next;
            fifo_count <= count_next;
            rx_valid   <= count_next != '0;
            rx_data    <= head_next;
            line_done  <= do_push && wb_dat_i[7:0] == 8'h0A;
        end
    end

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            state        <= IDLE;
            wcnt         <= '0;
            tcnt         <= '0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            uart_overrun <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            if (lsr_ack && wb_dat_i[9]) uart_overrun <= 1'b1;
            else if (flags_clr)         uart_overrun <= 1'b0;
            if (abort)                  bus_error <= 1'b1;
            else if (flags_clr)         bus_error <= 1'b0;

            case (state)
                IDLE: if (enable) state <= LSR_RD;
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else if (wcnt == PW'(POLL_INTERVAL - 1)) begin
                        state <= LSR_RD;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        tcnt     <= '0;
                        wb_adr_o <= (state == LSR_RD) ? 32'd5 : 32'd0;
                        wb_sel_o <= (state == LSR_RD) ? 4'b0010 : 4'b0001;
                    end else if (abort) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= WAIT;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!enable)                      state <= IDLE;
                        else if (state == RBR_RD)         state <= LSR_RD;
                        else if (wb_dat_i[8] && !full)    state <= RBR_RD;
                        else                              state <= WAIT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_poller.md
# uart_rx_poller

Testbench-side Wishbone master that sits directly downstream of the bench UART16550 (`uart0`) and consumes the characters the firmware transmits. It polls the UART Line Status Register and drains the Receiver Buffer Register into a local FIFO. It also flags line terminators and error conditions for the test-case tasks. It replaces hand-written `wb_mast` polling loops with a free-running, cycle-accurate receive path on the `clk_tb` domain.

## Interface
- POLL_INTERVAL, 16: idle cycles between LSR polls when no data is pending (1..255).
- FIFO_DEPTH, 16: receive FIFO entries; power of two, 2..256.
- ACK_TIMEOUT, 255: cycles to wait for `wb_ack_i` before aborting a bus cycle.

Ports:
- clk_tb  in  1  testbench clock.
- reset_tb  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable; sampled each cycle.
- wb_adr_o  out  32  Wishbone address; only [4:0] meaningful.
- wb_dat_o  out  32  Wishbone write data; always 0 (block only reads).
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte select.
- wb_cyc_o, wb_stb_o  out  1  cycle/strobe; always driven equal.
- wb_we_o  out  1  always 0.
- wb_ack_i, wb_err_i  in  1  slave acknowledge / error.
- rx_data  out  8  FIFO head byte.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pop; a pop occurs when rx_valid & rx_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- line_done  out  1  one-cycle pulse when byte 0x0A is pushed.
- uart_overrun  out  1  sticky; UART LSR bit 1 (OE) seen set.
- bus_error  out  1  sticky; wb_err_i or ack timeout seen.
- flags_clr  in  1  synchronous clear of uart_overrun and bus_error.

## Operation
- Register map, fixed:
  - LSR read: adr 5, sel 4'b0010, status in wb_dat_i[15:8].
  - RBR read: adr 0, sel 4'b0001, byte in wb_dat_i[7:0].
- FSM states: IDLE, WAIT, LSR_RD, RBR_RD.
  - IDLE: bus idle; go to LSR_RD when enable=1.
  - LSR_RD: issue read; on ack, latch LSR.
    - Set uart_overrun if LSR[1]=1.
    - If LSR[0]=1 (data ready) and FIFO not full, go to RBR_RD.
    - Otherwise go to WAIT.
  - RBR_RD: issue read; on ack, push wb_dat_i[7:0] and return to LSR_RD immediately. Back-to-back draining uses no poll delay.
  - WAIT: count POLL_INTERVAL cycles, then go to LSR_RD. Go to IDLE instead if enable=0.
- FIFO full: RBR is not read; the UART retains the byte, so there is no local drop. Re-poll after WAIT.
- Simultaneous push and pop: fifo_count unchanged; head advances. Pointers wrap modulo FIFO_DEPTH.
- Pop when empty is ignored.
- line_done pulses on the push of 0x0A only; 0x0D has no effect.
- wb_err_i with ack, or ACK_TIMEOUT cycles without ack:
  - drop cyc/stb next cycle;
  - set bus_error;
  - discard the data (no push);
  - go to WAIT.
- enable deasserted mid-cycle: complete the current bus cycle (including a push from RBR), then go to IDLE.
- flags_clr takes effect the cycle after sampling. If a set condition occurs in the same cycle, set wins.

## Timing
- All outputs are registered.
- Reset values:
  - wb_adr_o=0, wb_sel_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_dat_o=0;
  - rx_data=0, rx_valid=0, fifo_count=0;
  - line_done=0, uart_overrun=0, bus_error=0;
  - FSM=IDLE.
- Reset mid-transaction: cyc/stb drop asynchronously; FIFO contents lost.
- cyc/stb assert on the first clock edge after entering LSR_RD/RBR_RD, and hold until ack, err or timeout is sampled. They deassert on the following edge, so there is at least one idle cycle between bus cycles.
- Push latency: rx_valid rises 1 cycle after the RBR ack edge; line_done is coincident with that rise for 0x0A.
- Minimum byte throughput: LSR read + RBR read + 2 idle cycles, plus slave wait states.
- rx_data reflects the new head 1 cycle after a pop.

## Test plan
- Firmware sends "OK\n" at configured baud, rx_ready=1 → bytes 0x4F, 0x4B, 0x0A pop in order; line_done pulses exactly once, on 0x0A; fifo_count returns to 0.
- rx_ready=0, 20 bytes sent with FIFO_DEPTH=16 → fifo_count saturates at 16; no RBR read while full. Raise rx_ready → all 20 bytes received in order; uart_overrun stays 0 unless the UART FIFO overflowed.
- Force LSR[1]=1 on one poll → uart_overrun=1 and sticky. Pulse flags_clr → uart_overrun=0 the next cycle.
- Slave stalls ack for 255 cycles → cyc/stb drop, bus_error=1, no push, FSM polls again after POLL_INTERVAL.
- Deassert enable during an RBR read → the byte is still pushed, then no further cyc until enable=1. Assert reset_tb=0 mid-cycle → all outputs at reset values immediately.
